su_fwd_pipe: RTL and testbench



---
 rtl/su_pkg.sv | 15 +
 rtl/su_fwd_pipe_if.sv | 40 ++++
 rtl/su_rfile.sv | 36 +++
 rtl/su_fwd_pipe.sv | 140 ++++++++++++++
 tb/tb_su_fwd_pipe.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/su_pkg.sv
// Shared definitions for the scalar-unit operand/result pipeline.
package su_pkg;

    localparam int SU_WIDTH = 32;
    localparam int SU_NREG  = 32;

    // Load size encoding carried from EX into DF.
    typedef enum logic [1:0] {
        SU_LD_BYTE = 2'd0,
        SU_LD_HALF = 2'd1,
        SU_LD_WORD = 2'd2,
        SU_LD_RSVD = 2'd3
    } su_ld_size_e;

endpackage

// File: rtl/su_fwd_pipe_if.sv
// Operand/result pipeline bus: RD and EX requests in, EX operands and WB write out.
interface su_fwd_pipe_if
    import su_pkg::*;
#(
    parameter int WIDTH = SU_WIDTH,
    parameter int AW    = $clog2(SU_NREG)
);
    logic             stall_in;
    logic             rd_valid;
    logic [AW-1:0]    rd_rs;
    logic [AW-1:0]    rd_rt;
    logic             ex_valid;
    logic [AW-1:0]    ex_dest;
    logic [WIDTH-1:0] ex_data;
    logic             ex_load;
    su_ld_size_e      ex_ld_size;
    logic             ex_ld_signed;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             interlock;
    logic             wb_valid;
    logic [AW-1:0]    wb_dest;
    logic [WIDTH-1:0] wb_data;

    // Control/decode side.
    modport master (
        output stall_in, rd_valid, rd_rs, rd_rt,
        output ex_valid, ex_dest, ex_data, ex_load, ex_ld_size, ex_ld_signed, ld_data,
        input  rs_data, rt_data, interlock, wb_valid, wb_dest, wb_data
    );

    // Pipeline side.
    modport slave (
        input  stall_in, rd_valid, rd_rs, rd_rt,
        input  ex_valid, ex_dest, ex_data, ex_load, ex_ld_size, ex_ld_signed, ld_data,
        output rs_data, rt_data, interlock, wb_valid, wb_dest, wb_data
    );

endinterface

// File: rtl/su_rfile.sv
// NREG x WIDTH register file: two asynchronous read ports, one synchronous write port.
// With ZERO_REG set, register 0 reads as zero and writes to it are dropped.
module su_rfile
    import su_pkg::*;
#(
    parameter int WIDTH    = SU_WIDTH,
    parameter int NREG     = SU_NREG,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [NREG];
    logic             wr_zero;

    assign wr_zero = (ZERO_REG != 0) && (waddr == '0);

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we && !wr_zero) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = ((ZERO_REG != 0) && (raddr_a == '0)) ? '0 : mem[raddr_a];
    assign rdata_b = ((ZERO_REG != 0) && (raddr_b == '0)) ? '0 : mem[raddr_b];

endmodule

// File: rtl/su_fwd_pipe.sv
// Scalar-unit operand/result pipeline: EX->DF->WB result registers, register file,
// automatic operand forwarding (youngest producer wins), load-use interlock and
// load extension in DF.
module su_fwd_pipe
    import su_pkg::*;
#(
    parameter int WIDTH    = SU_WIDTH,
    parameter int NREG     = SU_NREG,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    su_fwd_pipe_if.slave  bus
);

    localparam int AW = $clog2(NREG);

    logic             df_valid;
    logic [AW-1:0]    df_dest;
    logic [WIDTH-1:0] df_data;
    logic             df_load;
    su_ld_size_e      df_ld_size;
    logic             df_ld_signed;
    logic [WIDTH-1:0] df_ext;

    logic             wb_valid;
    logic [AW-1:0]    wb_dest;
    logic [WIDTH-1:0] wb_data;

    logic [WIDTH-1:0] rs_q, rt_q;
    logic [WIDTH-1:0] rf_rs, rf_rt;
    logic [WIDTH-1:0] rs_fwd, rt_fwd;
    logic             ex_fwd_ok;
    logic             interlock;
    logic             rf_we;

    function automatic logic [WIDTH-1:0] ld_extend(input logic [WIDTH-1:0] d,
                                                   input su_ld_size_e size,
                                                   input logic sgn);
        case (size)
            SU_LD_BYTE: return {{(WIDTH-8){sgn & d[7]}}, d[7:0]};
            SU_LD_HALF: return {{(WIDTH-16){sgn & d[15]}}, d[15:0]};
            default:    return d;
        endcase
    endfunction

    // A load in EX has no data yet, so it is never a forwarding source.
    assign ex_fwd_ok = bus.ex_valid && !bus.ex_load;
    assign df_ext    = df_load ? ld_extend(bus.ld_data, df_ld_size, df_ld_signed) : df_data;

    // Priority: zero register, EX, DF, WB, then the array.
    function automatic logic [WIDTH-1:0] fwd_pick(input logic [AW-1:0] src,
                                                  input logic [WIDTH-1:0] rf_val);
        if ((ZERO_REG != 0) && (src == '0))        return '0;
        else if (ex_fwd_ok && (bus.ex_dest == src)) return bus.ex_data;
        else if (df_valid && (df_dest == src))     return df_ext;
        else if (wb_valid && (wb_dest == src))     return wb_data;
        else                                       return rf_val;
    endfunction

    // Forwarded operand values for the RD sources.
    always_comb begin
        rs_fwd = fwd_pick(bus.rd_rs, rf_rs);
        rt_fwd = fwd_pick(bus.rd_rt, rf_rt);
    end

    assign interlock = !reset && bus.rd_valid && bus.ex_valid && bus.ex_load &&
                       ((bus.ex_dest == bus.rd_rs) || (bus.ex_dest == bus.rd_rt)) &&
                       !((ZERO_REG != 0) && (bus.ex_dest == '0));

    // A held WB entry stays pending until the first unstalled edge.
    assign rf_we = wb_valid && !bus.stall_in;

    su_rfile #(
        .WIDTH    (WIDTH),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_rf (
        .clk     (clk),
        .we      (rf_we),
        .waddr   (wb_dest),
        .wdata   (wb_data),
        .raddr_a (bus.rd_rs),
        .rdata_a (rf_rs),
        .raddr_b (bus.rd_rt),
        .rdata_b (rf_rt)
    );

    // DF stage: capture the EX result/load descriptor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            df_valid     <= 1'b0;
            df_dest      <= '0;
            df_data      <= '0;
            df_load      <= 1'b0;
            df_ld_size   <= SU_LD_BYTE;
            df_ld_signed <= 1'b0;
        end else if (!bus.stall_in) begin
            df_valid     <= bus.ex_valid;
            df_dest      <= bus.ex_dest;
            df_data      <= bus.ex_data;
            df_load      <= bus.ex_load;
            df_ld_size   <= bus.ex_ld_size;
            df_ld_signed <= bus.ex_ld_signed;
        end
    end

    // WB stage: capture the extended DF result for the register-file write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
        end else if (!bus.stall_in) begin
            wb_valid <= df_valid;
            wb_dest  <= df_dest;
            wb_data  <= df_ext;
        end
    end

    // EX operand registers: hold on stall or load-use interlock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q <= '0;
            rt_q <= '0;
        end else if (!bus.stall_in && !interlock) begin
            rs_q <= rs_fwd;
            rt_q <= rt_fwd;
        end
    end

    assign bus.rs_data   = rs_q;
    assign bus.rt_data   = rt_q;
    assign bus.interlock = interlock;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_dest   = wb_dest;
    assign bus.wb_data   = wb_data;

endmodule

// File: tb/tb_su_fwd_pipe.sv
// Directed bench for su_fwd_pipe: forwarding paths, load-use interlock, load
// extension, zero register, stall and mid-operation reset.
module tb_su_fwd_pipe;
    import su_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    su_fwd_pipe_if #(.WIDTH(32), .AW(5)) bus ();

    su_fwd_pipe #(.WIDTH(32), .NREG(32), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [4:0] d, input logic [31:0] data,
                          input logic ld, input su_ld_size_e sz, input logic sg);
        bus.ex_valid     = v;
        bus.ex_dest      = d;
        bus.ex_data      = data;
        bus.ex_load      = ld;
        bus.ex_ld_size   = sz;
        bus.ex_ld_signed = sg;
    endtask

    task automatic ex_off();
        set_ex(1'b0, 5'd0, 32'h0, 1'b0, SU_LD_WORD, 1'b0);
    endtask

    task automatic set_rd(input logic v, input logic [4:0] rs, input logic [4:0] rt);
        bus.rd_valid = v;
        bus.rd_rs    = rs;
        bus.rd_rt    = rt;
    endtask

    initial begin
        reset        = 1'b1;
        bus.stall_in = 1'b0;
        bus.ld_data  = 32'h0;
        ex_off();
        set_rd(1'b0, 5'd0, 5'd0);
        #2;

        // Reset state, with a load-use pattern on the inputs.
        set_ex(1'b1, 5'd1, 32'h5, 1'b1, SU_LD_WORD, 1'b0);
        set_rd(1'b1, 5'd1, 5'd0);
        #1;
        chk("rst_interlock", {31'd0, bus.interlock}, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wb_dest", {27'd0, bus.wb_dest}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_rs", bus.rs_data, 32'd0);
        chk("rst_rt", bus.rt_data, 32'd0);
        ex_off();
        set_rd(1'b0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;

        // r5 = 0x12345678 forwarded from EX, DF, WB, then read from the array.
        set_ex(1'b1, 5'd5, 32'h1234_5678, 1'b0, SU_LD_WORD, 1'b0);
        set_rd(1'b1, 5'd5, 5'd0);
        tick();
        chk("ex_fwd_r5", bus.rs_data, 32'h1234_5678);
        ex_off();
        tick();
        chk("df_fwd_r5", bus.rs_data, 32'h1234_5678);
        chk("wb_valid_r5", {31'd0, bus.wb_valid}, 32'd1);
        chk("wb_dest_r5", {27'd0, bus.wb_dest}, 32'd5);
        chk("wb_data_r5", bus.wb_data, 32'h1234_5678);
        tick();
        chk("wb_fwd_r5", bus.rs_data, 32'h1234_5678);
        chk("wb_empty", {31'd0, bus.wb_valid}, 32'd0);
        tick();
        chk("rf_r5", bus.rs_data, 32'h1234_5678);

        // EX beats DF, DF beats WB, WB beats the array.
        set_ex(1'b1, 5'd3, 32'h1111_1111, 1'b0, SU_LD_WORD, 1'b0);
        set_rd(1'b0, 5'd5, 5'd0);
        tick();
        set_ex(1'b1, 5'd3, 32'hAAAA_0000, 1'b0, SU_LD_WORD, 1'b0);
        set_rd(1'b1, 5'd5, 5'd3);
        tick();
        chk("ex_prio_rt", bus.rt_data, 32'hAAAA_0000);
        chk("ex_prio_rs", bus.rs_data, 32'h1234_5678);
        ex_off();
        tick();
        chk("df_over_wb", bus.rt_data, 32'hAAAA_0000);
        tick();
        chk("wb_over_rf", bus.rt_data, 32'hAAAA_0000);
        tick();
        chk("rf_r3", bus.rt_data, 32'hAAAA_0000);

        // Load-use on rs, signed byte: one stall cycle, then DF forwards df_ext.
        set_ex(1'b1, 5'd7, 32'hCAFE_0000, 1'b1, SU_LD_BYTE, 1'b1);
        set_rd(1'b1, 5'd7, 5'd3);
        #1;
        chk("lu_interlock_rs", {31'd0, bus.interlock}, 32'd1);
        tick();
        chk("lu_hold_rs", bus.rs_data, 32'h1234_5678);
        chk("lu_hold_rt", bus.rt_data, 32'hAAAA_0000);
        ex_off();
        bus.ld_data = 32'h0000_00F0;
        #1;
        chk("lu_bubble_clear", {31'd0, bus.interlock}, 32'd0);
        tick();
        chk("lb_signed_rs", bus.rs_data, 32'hFFFF_FFF0);
        chk("lb_signed_wb", bus.wb_data, 32'hFFFF_FFF0);

        // Load-use on rt, unsigned byte.
        set_ex(1'b1, 5'd8, 32'h0, 1'b1, SU_LD_BYTE, 1'b0);
        set_rd(1'b1, 5'd7, 5'd8);
        bus.ld_data = 32'h0;
        #1;
        chk("lu_interlock_rt", {31'd0, bus.interlock}, 32'd1);
        tick();
        chk("lu_hold_rt2", bus.rt_data, 32'hAAAA_0000);
        ex_off();
        bus.ld_data = 32'h0000_00F0;
        tick();
        chk("lb_unsigned_rt", bus.rt_data, 32'h0000_00F0);
        chk("rf_r7_signed", bus.rs_data, 32'hFFFF_FFF0);

        // Signed half; rd_valid=0 suppresses the interlock.
        set_ex(1'b1, 5'd10, 32'h0, 1'b1, SU_LD_HALF, 1'b1);
        set_rd(1'b0, 5'd10, 5'd10);
        #1;
        chk("no_il_rd_invalid", {31'd0, bus.interlock}, 32'd0);
        tick();
        ex_off();
        bus.ld_data = 32'h1234_8001;
        set_rd(1'b1, 5'd10, 5'd10);
        tick();
        chk("lh_signed", bus.rs_data, 32'hFFFF_8001);

        // Word load, then reserved size behaving as word.
        set_ex(1'b1, 5'd11, 32'h0, 1'b1, SU_LD_WORD, 1'b1);
        set_rd(1'b0, 5'd0, 5'd0);
        tick();
        ex_off();
        bus.ld_data = 32'h89AB_CDEF;
        set_rd(1'b1, 5'd11, 5'd0);
        tick();
        chk("lw_word", bus.rs_data, 32'h89AB_CDEF);
        set_ex(1'b1, 5'd12, 32'h0, 1'b1, SU_LD_RSVD, 1'b1);
        set_rd(1'b0, 5'd0, 5'd0);
        tick();
        ex_off();
        bus.ld_data = 32'h0000_00F0;
        set_rd(1'b1, 5'd0, 5'd12);
        tick();
        chk("ld_rsvd_word", bus.rt_data, 32'h0000_00F0);
        bus.ld_data = 32'h0;

        // r0 writes dropped and never forwarded; no interlock on r0.
        set_ex(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, SU_LD_WORD, 1'b0);
        set_rd(1'b1, 5'd0, 5'd0);
        tick();
        chk("r0_ex_rs", bus.rs_data, 32'd0);
        chk("r0_ex_rt", bus.rt_data, 32'd0);
        set_ex(1'b1, 5'd0, 32'h0, 1'b1, SU_LD_BYTE, 1'b1);
        #1;
        chk("r0_no_interlock", {31'd0, bus.interlock}, 32'd0);
        tick();
        chk("r0_df", bus.rs_data, 32'd0);
        ex_off();
        tick();
        chk("r0_wb", bus.rs_data, 32'd0);
        tick();
        tick();
        chk("r0_rf", bus.rs_data, 32'd0);

        // Stall with WB holding r9=0x55 over an array value of 0x33.
        set_ex(1'b1, 5'd9, 32'h33, 1'b0, SU_LD_WORD, 1'b0);
        set_rd(1'b0, 5'd0, 5'd0);
        tick();
        ex_off();
        tick();
        tick();
        tick();
        chk("r9_pre", dut.u_rf.mem[9], 32'h33);
        set_ex(1'b1, 5'd9, 32'h55, 1'b0, SU_LD_WORD, 1'b0);
        tick();
        ex_off();
        set_rd(1'b1, 5'd9, 5'd9);
        tick();
        chk("r9_df_fwd", bus.rs_data, 32'h55);
        bus.stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_write", dut.u_rf.mem[9], 32'h33);
            chk("stall_wb_held", {31'd0, bus.wb_valid}, 32'd1);
            chk("stall_rs_held", bus.rs_data, 32'h55);
        end
        bus.stall_in = 1'b0;
        tick();
        chk("release_commit", dut.u_rf.mem[9], 32'h55);
        chk("release_rs_wb", bus.rs_data, 32'h55);
        chk("release_wb_empty", {31'd0, bus.wb_valid}, 32'd0);
        tick();
        chk("r9_rf", bus.rt_data, 32'h55);

        // Reset while DF holds r4=0x99 over an array value of 0x44.
        set_ex(1'b1, 5'd4, 32'h44, 1'b0, SU_LD_WORD, 1'b0);
        set_rd(1'b0, 5'd0, 5'd0);
        tick();
        ex_off();
        tick();
        tick();
        tick();
        set_ex(1'b1, 5'd4, 32'h99, 1'b0, SU_LD_WORD, 1'b0);
        set_rd(1'b1, 5'd4, 5'd4);
        tick();
        chk("r4_ex_fwd", bus.rs_data, 32'h99);
        ex_off();
        reset = 1'b1;
        #1;
        chk("mid_rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("mid_rst_rs", bus.rs_data, 32'd0);
        chk("mid_rst_rt", bus.rt_data, 32'd0);
        tick();
        reset = 1'b0;
        chk("mid_rst_r4_array", dut.u_rf.mem[4], 32'h44);
        tick();
        chk("post_rst_r4", bus.rs_data, 32'h44);
        tick();
        chk("post_rst_r4_array", dut.u_rf.mem[4], 32'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
